// File: rtl/mem_access_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// A transfer completes in any cycle where dmem_req and dmem_ready are both high.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage: issues data-memory accesses from the EX/MEM packet, aligns and
// extends loads, builds store byte-enables, selects write-back data and
// registers the MEM/WB packet. Stalls the front of the pipe while an access
// waits for dmem_ready, and aborts with bus_err after TIMEOUT cycles.
module mem_access #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int CTRL_SIZE = 21,
  parameter int TIMEOUT   = 16,
  parameter int REG_BITS  = $clog2(REG_COUNT)
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic [REG_BITS+1+CTRL_SIZE-7+REG_WIDTH*3-1:0] exc_mem_reg,
  mem_access_if.master                                 dmem,
  output logic                                         mem_stall,
  output logic [31:0]                                  wb_data_ex_mem,
  output logic [REG_BITS-1:0]                          rd_ex_mem,
  output logic                                         wen_ex_mem,
  output logic [REG_BITS+32:0]                         mem_wb_reg,
  output logic                                         misalign_err,
  output logic                                         bus_err
);

  localparam int MC_W  = CTRL_SIZE - 7;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  // Unpacked EX/MEM fields; forced to zero under reset so every combinational
  // output (including dmem_req) is quiet while rstn is low.
  logic [REG_BITS-1:0] rd_p0;
  logic                wen_p0;
  logic [MC_W-1:0]     mctrl_p0;
  logic [31:0]         alu_p0, sdata_p0, rpc_p0;

  logic       mem_read, mem_write, mem_op;
  logic [2:0] f3;
  logic [1:0] wb_sel, a_lo;
  logic       is_half, is_word, misalign, access;
  logic       req, abort;
  logic [31:0] wb_data;
  logic       ctrl_unused;

  // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  a,
                                              input logic [2:0]  fn);
    logic [31:0] sh;
    sh = rdata >> {a, 3'b000};
    case (fn)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {24'b0, sh[7:0]};
      3'b101:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << a;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicating the datum lets the memory pick lanes purely from dmem_be.
  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  // ---- stage p0: EX/MEM packet decode ----
  assign {rd_p0, wen_p0, mctrl_p0, alu_p0, sdata_p0, rpc_p0} = rstn ? exc_mem_reg : '0;

  assign mem_read    = mctrl_p0[13];
  assign mem_write   = mctrl_p0[12];
  assign f3          = mctrl_p0[11:9];
  assign wb_sel      = mctrl_p0[8:7];
  assign ctrl_unused = ^mctrl_p0[6:0];
  assign mem_op      = mem_read | mem_write;
  assign a_lo        = alu_p0[1:0];
  assign is_half     = (f3[1:0] == 2'b01);
  assign is_word     = (f3 == 3'b010);
  assign misalign    = mem_op & ((is_half & a_lo[0]) | (is_word & (a_lo != 2'b00)));
  assign access      = mem_op & ~misalign;

  assign wb_data_ex_mem = alu_p0;
  assign rd_ex_mem      = rd_p0;
  assign wen_ex_mem     = wen_p0;

  // Access FSM state and wait counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: enter WAIT when the first request cycle misses ready; leave on
  // ready or when the wait counter has reached its limit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (access && !dmem.dmem_ready) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (dmem.dmem_ready || (cnt == CNT_LAST)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Memory port, stall and write-back data selection.
  always_comb begin
    req             = (state == WAIT) | access;
    abort           = (state == WAIT) & ~dmem.dmem_ready & (cnt == CNT_LAST);
    mem_stall       = req & ~dmem.dmem_ready & ~abort;
    dmem.dmem_req   = req;
    dmem.dmem_we    = req & mem_write;
    dmem.dmem_addr  = {alu_p0[31:2], 2'b00};
    dmem.dmem_wdata = store_wdata(f3[1:0], sdata_p0);
    dmem.dmem_be    = (req & mem_write) ? store_be(f3[1:0], a_lo) : 4'b0000;
    case (wb_sel)
      2'b01:   wb_data = load_extend(dmem.dmem_rdata, a_lo, f3);
      2'b10:   wb_data = rpc_p0;
      default: wb_data = alu_p0;
    endcase
  end

  // ---- stage p1: MEM/WB register; bubbles while stalled, write suppressed on error ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_wb_reg   <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if (mem_stall)
        mem_wb_reg <= {rd_p0, 1'b0, 32'b0};
      else
        mem_wb_reg <= {rd_p0, wen_p0 & ~(misalign | abort), wb_data};
      misalign_err <= misalign;
      bus_err      <= abort;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vectors push expected responses into a
// scoreboard tagged with the cycle they are due; a monitor on the falling
// edge pops and compares every entry whose cycle has arrived.
module tb_mem_access;
  logic         clk = 1'b0;
  logic         rstn;
  logic [115:0] exc;
  logic         mem_stall;
  logic [31:0]  wb_data_ex_mem;
  logic [4:0]   rd_ex_mem;
  logic         wen_ex_mem;
  logic [37:0]  mem_wb_reg;
  logic         misalign_err;
  logic         bus_err;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .exc_mem_reg    (exc),
    .dmem           (bus.master),
    .mem_stall      (mem_stall),
    .wb_data_ex_mem (wb_data_ex_mem),
    .rd_ex_mem      (rd_ex_mem),
    .wen_ex_mem     (wen_ex_mem),
    .mem_wb_reg     (mem_wb_reg),
    .misalign_err   (misalign_err),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  localparam int S_WB = 0, S_MIS = 1, S_BUS = 2, S_REQ = 3, S_STL = 4, S_BE = 5,
                 S_WD = 6, S_AD = 7, S_WE = 8, S_FWD = 9, S_RD = 10, S_WEN = 11, S_RDW = 12;

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] act(input int sel);
    case (sel)
      S_WB:    return 64'(mem_wb_reg);
      S_MIS:   return 64'(misalign_err);
      S_BUS:   return 64'(bus_err);
      S_REQ:   return 64'(bus.dmem_req);
      S_STL:   return 64'(mem_stall);
      S_BE:    return 64'(bus.dmem_be);
      S_WD:    return 64'(bus.dmem_wdata);
      S_AD:    return 64'(bus.dmem_addr);
      S_WE:    return 64'(bus.dmem_we);
      S_FWD:   return 64'(wb_data_ex_mem);
      S_RD:    return 64'(rd_ex_mem);
      S_WEN:   return 64'(wen_ex_mem);
      S_RDW:   return 64'(mem_wb_reg[37:32]);
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  // Monitor: compare every scoreboard entry due in the current cycle.
  always @(negedge clk) begin : monitor
    int i;
    logic [63:0] a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        a = act(sb[i].sel);
        n_total = n_total + 1;
        if (a !== sb[i].exp) begin
          n_bad = n_bad + 1;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", sb[i].name, a, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic expect_at(input int off, input int sel, input logic [63:0] v, input string nm);
    chk_t c;
    c.due  = cyc + off;
    c.sel  = sel;
    c.exp  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  function automatic logic [115:0] mk(input logic [4:0] rd, input logic wen, input logic mr,
                                      input logic mw, input logic [2:0] f3, input logic [1:0] sel,
                                      input logic [31:0] alu, input logic [31:0] sd,
                                      input logic [31:0] rpc);
    return {rd, wen, mr, mw, f3, sel, 7'b0, alu, sd, rpc};
  endfunction

  function automatic logic [63:0] pkt(input logic [4:0] rd, input logic wen, input logic [31:0] d);
    return {26'b0, rd, wen, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] expv, input string nm);
    exc = mk(rd, 1'b1, 1'b1, 1'b0, f3, 2'b01, addr, 32'h0, 32'h0);
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = rdata;
    expect_at(0, S_REQ, 64'd1, {nm, "_req"});
    expect_at(0, S_STL, 64'd0, {nm, "_stall"});
    expect_at(0, S_AD,  64'({addr[31:2], 2'b00}), {nm, "_addr"});
    expect_at(0, S_BE,  64'd0, {nm, "_be"});
    expect_at(1, S_WB,  pkt(rd, 1'b1, expv), {nm, "_wb"});
    step();
  endtask

  task automatic do_store(input logic mr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd,
                          input string nm);
    exc = mk(5'd3, 1'b0, mr, 1'b1, f3, 2'b00, addr, d, 32'h0);
    bus.dmem_ready = 1'b1;
    expect_at(0, S_REQ, 64'd1, {nm, "_req"});
    expect_at(0, S_WE,  64'd1, {nm, "_we"});
    expect_at(0, S_STL, 64'd0, {nm, "_stall"});
    expect_at(0, S_BE,  64'(be), {nm, "_be"});
    expect_at(0, S_WD,  64'(wd), {nm, "_wdata"});
    expect_at(1, S_WB,  pkt(5'd3, 1'b0, addr), {nm, "_wb"});
    step();
  endtask

  task automatic do_misalign(input logic [4:0] rd, input logic mr, input logic mw,
                             input logic [2:0] f3, input logic [31:0] addr, input string nm);
    exc = mk(rd, 1'b1, mr, mw, f3, 2'b01, addr, 32'h5555, 32'h0);
    bus.dmem_ready = 1'b1;
    expect_at(0, S_REQ, 64'd0, {nm, "_req"});
    expect_at(0, S_STL, 64'd0, {nm, "_stall"});
    expect_at(0, S_BE,  64'd0, {nm, "_be"});
    expect_at(1, S_RDW, 64'({rd, 1'b0}), {nm, "_wen"});
    expect_at(1, S_MIS, 64'd1, {nm, "_err"});
    step();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rstn = 1'b0;
    exc = '0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;

    // Reset state
    step();
    n_total = n_total + 1;
    if (mem_wb_reg !== 38'd0) begin
      n_bad = n_bad + 1;
      $display("FAIL direct_rst_wb: got %0h expected 0", mem_wb_reg);
    end
    expect_at(0, S_WB,  64'd0, "rst_wb");
    expect_at(0, S_REQ, 64'd0, "rst_req");
    expect_at(0, S_STL, 64'd0, "rst_stall");
    expect_at(0, S_MIS, 64'd0, "rst_mis");
    expect_at(0, S_BUS, 64'd0, "rst_bus");
    step();
    rstn = 1'b1;

    // ALU pass-through
    exc = mk(5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'h1234, 32'h0, 32'h0);
    expect_at(0, S_REQ, 64'd0, "add_req");
    expect_at(0, S_STL, 64'd0, "add_stall");
    expect_at(0, S_FWD, 64'h1234, "add_fwd");
    expect_at(0, S_RD,  64'd5, "add_rd");
    expect_at(0, S_WEN, 64'd1, "add_wen");
    expect_at(1, S_WB,  pkt(5'd5, 1'b1, 32'h1234), "add_wb");
    step();
    n_total = n_total + 1;
    if (mem_wb_reg !== {5'd5, 1'b1, 32'h1234}) begin
      n_bad = n_bad + 1;
      $display("FAIL direct_add_wb: got %0h expected %0h", mem_wb_reg, {5'd5, 1'b1, 32'h1234});
    end

    // Loads with ready in the request cycle
    do_load(5'd6, 3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80, "lb");
    n_total = n_total + 1;
    if (mem_wb_reg !== {5'd6, 1'b1, 32'hFFFF_FF80}) begin
      n_bad = n_bad + 1;
      $display("FAIL direct_lb_wb: got %0h expected %0h", mem_wb_reg, {5'd6, 1'b1, 32'hFFFF_FF80});
    end
    do_load(5'd6, 3'b100, 32'h101, 32'h1234_5678, 32'h0000_0056, "lbu");
    do_load(5'd7, 3'b001, 32'h102, 32'hBEEF_0000, 32'hFFFF_BEEF, "lh");
    do_load(5'd7, 3'b101, 32'h102, 32'hBEEF_0000, 32'h0000_BEEF, "lhu");
    do_load(5'd8, 3'b001, 32'h100, 32'h0000_7FFF, 32'h0000_7FFF, "lh_pos");
    do_load(5'd8, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");
    do_load(5'd9, 3'b011, 32'h104, 32'h0123_4567, 32'h0123_4567, "f3_undef");

    // Write-back select: return_pc and the alternate ALU encoding
    exc = mk(5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 2'b10, 32'h55, 32'h0, 32'h400);
    expect_at(1, S_WB, pkt(5'd1, 1'b1, 32'h400), "rpc_wb");
    step();
    exc = mk(5'd2, 1'b1, 1'b0, 1'b0, 3'b000, 2'b11, 32'h77, 32'h0, 32'h400);
    expect_at(1, S_WB, pkt(5'd2, 1'b1, 32'h77), "sel11_wb");
    step();

    // SH with ready arriving after three stall cycles
    bus.dmem_ready = 1'b0;
    exc = mk(5'd7, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 32'h202, 32'hABCD_1234, 32'h0);
    for (int k = 0; k < 3; k++) begin
      expect_at(0, S_REQ, 64'd1, "sh_wait_req");
      expect_at(0, S_STL, 64'd1, "sh_wait_stall");
      expect_at(0, S_BE,  64'hC, "sh_be");
      expect_at(0, S_WD,  64'h1234_1234, "sh_wdata");
      expect_at(0, S_AD,  64'h200, "sh_addr");
      expect_at(0, S_WE,  64'd1, "sh_we");
      expect_at(1, S_WB,  pkt(5'd7, 1'b0, 32'h0), "sh_bubble");
      step();
    end
    bus.dmem_ready = 1'b1;
    expect_at(0, S_REQ, 64'd1, "sh_done_req");
    expect_at(0, S_STL, 64'd0, "sh_done_stall");
    expect_at(0, S_BE,  64'hC, "sh_done_be");
    expect_at(1, S_WB,  pkt(5'd7, 1'b0, 32'h202), "sh_done_wb");
    step();

    // Other store sizes, and read+write treated as write
    do_store(1'b0, 3'b000, 32'h301, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, "sb");
    do_store(1'b0, 3'b000, 32'h303, 32'h0000_00CD, 4'b1000, 32'hCDCD_CDCD, "sb3");
    do_store(1'b0, 3'b010, 32'h400, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, "sw");
    do_store(1'b1, 3'b010, 32'h404, 32'h1122_3344, 4'b1111, 32'h1122_3344, "rw_store");

    // Misaligned accesses
    do_misalign(5'd8, 1'b1, 1'b0, 3'b010, 32'h101, "mis_lw");
    n_total = n_total + 1;
    if (misalign_err !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL direct_mis_lw: got %0h expected 1", misalign_err);
    end
    exc = mk(5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
    expect_at(1, S_MIS, 64'd0, "mis_pulse_end");
    step();
    do_misalign(5'd9, 1'b0, 1'b1, 3'b001, 32'h203, "mis_sh");
    do_misalign(5'd10, 1'b1, 1'b0, 3'b101, 32'h105, "mis_lhu");
    exc = mk(5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
    step();

    // Timeout: ready never arrives
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'h0;
    exc = mk(5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h500, 32'h0, 32'h0);
    for (int k = 0; k < 15; k++) begin
      expect_at(0, S_REQ, 64'd1, "to_req");
      expect_at(0, S_STL, 64'd1, "to_stall");
      expect_at(1, S_WB,  pkt(5'd10, 1'b0, 32'h0), "to_bubble");
      expect_at(1, S_BUS, 64'd0, "to_no_bus_err");
      step();
    end
    expect_at(0, S_REQ, 64'd1, "to_last_req");
    expect_at(0, S_STL, 64'd0, "to_last_stall");
    expect_at(1, S_RDW, 64'({5'd10, 1'b0}), "to_wen");
    expect_at(1, S_BUS, 64'd1, "to_bus_err");
    expect_at(2, S_BUS, 64'd0, "to_bus_pulse_end");
    step();
    n_total = n_total + 1;
    if (bus_err !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL direct_bus_err: got %0h expected 1", bus_err);
    end
    exc = mk(5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
    expect_at(0, S_REQ, 64'd0, "to_after_req");
    expect_at(0, S_STL, 64'd0, "to_after_stall");
    step();

    // Asynchronous reset while a store waits
    exc = mk(5'd11, 1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 32'h600, 32'h99, 32'h0);
    expect_at(0, S_STL, 64'd1, "ar_stall0");
    step();
    expect_at(0, S_REQ, 64'd1, "ar_wait_req");
    expect_at(0, S_STL, 64'd1, "ar_wait_stall");
    step();
    #1;
    rstn = 1'b0;
    expect_at(0, S_WB,  64'd0, "ar_wb");
    expect_at(0, S_REQ, 64'd0, "ar_req");
    expect_at(0, S_STL, 64'd0, "ar_stall");
    expect_at(0, S_BE,  64'd0, "ar_be");
    expect_at(0, S_WE,  64'd0, "ar_we");
    expect_at(0, S_WD,  64'd0, "ar_wdata");
    expect_at(0, S_AD,  64'd0, "ar_addr");
    expect_at(0, S_FWD, 64'd0, "ar_fwd");
    expect_at(0, S_RD,  64'd0, "ar_rd");
    step();
    rstn = 1'b1;
    exc = mk(5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
    bus.dmem_ready = 1'b0;
    expect_at(0, S_REQ, 64'd0, "post_rst_req");
    expect_at(0, S_STL, 64'd0, "post_rst_stall");
    step();
    do_load(5'd12, 3'b010, 32'h700, 32'h0BAD_F00D, 32'h0BAD_F00D, "post_rst_lw");

    exc = mk(5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
    step();
    step();
    step();

    while (sb.size() > 0) begin
      n_total = n_total + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: got unchecked expected checked (due %0d)", sb[0].name, sb[0].due);
      sb.delete(0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
